display_tx: RTL and testbench
=============================

DISPLAY_TX -- requirements
Module: display_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port MDR  input  16  memory data register value written by the CPU.
REQ-005 SHALL have port LD_DSR  input  1  CPU store to display status register this cycle.
REQ-006 SHALL have port LD_DDR  input  1  CPU store to display data register this cycle.
REQ-007 SHALL have port DDR  output  16  display data register, last accepted character.
REQ-008 SHALL have port DSR  output  16  display status register; bit 15 Ready, bit 14 INT_EN, bits 13:0 software scratch.
REQ-009 SHALL have port WR  output  1  one-cycle write-acknowledge pulse to the memory controller.
REQ-010 SHALL have port INT  output  1  interrupt request, combinational DSR[15] & DSR[14].
REQ-011 SHALL have port tx  output  1  serial line, 8N1, idle high, LSB first.

Function
REQ-012 SHALL accept LD_DSR in any state: DSR[14:0] <= MDR[14:0] on that edge; DSR[15] not writable by software.
REQ-013 SHALL accept LD_DDR only when DSR[15]=1: DDR <= MDR, DSR[15] <= 0, FSM IDLE->START, on that edge.
REQ-014 SHALL ignore LD_DDR while DSR[15]=0: DDR, DSR, frame in progress and WR all unchanged.
REQ-015 SHALL give LD_DSR priority when LD_DSR and LD_DDR are both high: DSR[14:0] written, LD_DDR ignored that cycle.
REQ-016 SHALL drive WR=1 for exactly the one cycle after an accepted LD_DSR or LD_DDR, 0 otherwise.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP; tx=1 in IDLE and STOP, tx=0 in START, tx=DDR[bit_idx] in DATA.
REQ-018 SHALL hold each of START, each DATA bit, and STOP for exactly CLKS_PER_BIT cycles, using a baud counter that reloads to 0 on each state or bit change.
REQ-019 SHALL use a 3-bit bit index 0..7 in DATA; index 7 at terminal count -> STOP, index wraps to 0.
REQ-020 SHALL transmit only DDR[7:0]; DDR[15:8] stored but not sent.
REQ-021 SHALL drive tx low in the cycle immediately after the accepting LD_DDR edge.
REQ-022 SHALL set DSR[15] <= 1 and return to IDLE on the last cycle of STOP, i.e. 10*CLKS_PER_BIT cycles after the accepting edge.
REQ-023 SHALL accept a new LD_DDR on the cycle DSR[15] reads 1, giving back-to-back frames with no extra idle bit.
REQ-024 SHALL leave DSR[14:0] unaffected by transmission; an LD_DSR mid-frame SHALL NOT disturb tx timing.
REQ-025 SHALL assert INT whenever Ready and INT_EN are both 1, including immediately after reset if software sets INT_EN.

Reset
REQ-026 SHALL, on rst_n=0, immediately force DSR=16'h8000, DDR=16'h0000, WR=0, tx=1, FSM=IDLE, counters=0.
REQ-027 SHALL abort any frame in progress on reset; tx returns high asynchronously with no stop bit generated.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 SHALL cover, with CLKS_PER_BIT=4: reset, LD_DDR MDR=16'h0041 -> DSR=16'h0000 next cycle, WR one-cycle pulse, tx = 0,1,0,0,0,0,0,1,0,1 per 4-cycle bit, DSR[15]=1 at cycle 40.
REQ-030 SHALL cover busy write: second LD_DDR MDR=16'h0055 at cycle 10 of a frame -> DDR stays 16'h0041, WR stays 0, frame bits unchanged.
REQ-031 SHALL cover simultaneous LD_DSR MDR=16'h4000 and LD_DDR -> DSR=16'hC000, no frame started, INT=1.
REQ-032 SHALL cover back-to-back: LD_DDR 16'h00FF on the cycle Ready rises -> tx start bit next cycle, no idle gap.
REQ-033 SHALL cover reset mid-frame at cycle 17 -> tx=1 and DSR=16'h8000 before the next clk edge, DDR=16'h0000.
REQ-034 SHALL cover INT: LD_DSR MDR=16'h4000 while idle -> INT=1; LD_DDR -> INT=0 until frame end, then INT=1.

Source files
------------

// File: rtl/display_tx.sv
// Memory-mapped display transmitter: DSR/DDR register pair feeding an 8N1 serial line.
// The Ready bit gates new characters and together with INT_EN raises INT.
module display_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] MDR,
    input  logic        LD_DSR,
    input  logic        LD_DDR,
    output logic [15:0] DDR,
    output logic [15:0] DSR,
    output logic        WR,
    output logic        INT,
    output logic        tx
);

    // state | meaning
    // IDLE  | line high, Ready set, waiting for a character
    // START | start bit (low)
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (high); Ready is restored as it ends
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_TC = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_ready;
    logic [14:0] r_dsr_low;
    logic [15:0] r_ddr;
    logic        r_wr;
    logic        r_tx;

    logic        w_baud_tc;
    logic        w_accept_ddr;
    logic [2:0]  w_next_idx;

    assign w_baud_tc    = (r_baud_cnt == BAUD_TC);
    // LD_DSR wins a same-cycle collision, so the character store is dropped.
    assign w_accept_ddr = LD_DDR && r_ready && !LD_DSR;
    assign w_next_idx   = r_bit_idx + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_ready    <= 1'b1;
            r_dsr_low  <= '0;
            r_ddr      <= '0;
            r_wr       <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_wr <= 1'b0;
            if (LD_DSR) begin
                r_dsr_low <= MDR[14:0];
                r_wr      <= 1'b1;
            end else if (w_accept_ddr) begin
                r_ddr   <= MDR;
                r_ready <= 1'b0;
                r_wr    <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept_ddr) begin
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_baud_cnt <= '0;
                    end
                end
                START: begin
                    if (w_baud_tc) begin
                        r_state    <= DATA;
                        r_tx       <= r_ddr[0];
                        r_bit_idx  <= '0;
                        r_baud_cnt <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_baud_tc) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= w_next_idx;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx <= r_ddr[w_next_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (w_baud_tc) begin
                        r_state    <= IDLE;
                        r_ready    <= 1'b1;
                        r_baud_cnt <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

    assign DDR = r_ddr;
    assign DSR = {r_ready, r_dsr_low};
    assign WR  = r_wr;
    assign INT = r_ready & r_dsr_low[14];
    assign tx  = r_tx;

endmodule

// File: tb/tb_display_tx.sv
// Directed bench for display_tx at CLKS_PER_BIT=4; expected values are hand-derived.
module tb_display_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] MDR = '0;
    logic        LD_DSR = 1'b0;
    logic        LD_DDR = 1'b0;
    logic [15:0] DDR;
    logic [15:0] DSR;
    logic        WR;
    logic        INT;
    logic        tx;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [14:0] exp_low = '0;
    logic [15:0] exp_ddr = '0;

    display_tx #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .MDR(MDR), .LD_DSR(LD_DSR), .LD_DDR(LD_DDR),
        .DDR(DDR), .DSR(DSR), .WR(WR), .INT(INT), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int c);
        int k;
        k = c / 4;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (DSR !== 16'h8000) begin n_fail++; $display("FAIL reset_dsr got %h want 8000", DSR); end
        n_cmp++; if (DDR !== 16'h0000) begin n_fail++; $display("FAIL reset_ddr got %h want 0000", DDR); end
        n_cmp++; if (WR !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", WR); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b want 0", INT); end
        rst_n = 1'b1;
        exp_low = '0;
        exp_ddr = '0;
        tick();
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx got %b want 1", tx); end
    endtask

    // Drive one accepted LD_DDR; afterwards we sit at cycle 0 of the frame.
    task automatic accept(input logic [15:0] v);
        MDR = v;
        LD_DDR = 1'b1;
        tick();
        LD_DDR = 1'b0;
        exp_ddr = v;
        n_cmp++; if (DSR !== {1'b0, exp_low}) begin n_fail++; $display("FAIL accept_dsr got %h want %h", DSR, {1'b0, exp_low}); end
        n_cmp++; if (WR !== 1'b1) begin n_fail++; $display("FAIL accept_wr got %b want 1", WR); end
        n_cmp++; if (DDR !== v) begin n_fail++; $display("FAIL accept_ddr got %h want %h", DDR, v); end
    endtask

    // Walk cycles 0..40 of a frame, optionally injecting a busy LD_DDR or a mid-frame LD_DSR.
    task automatic check_frame(input logic [7:0] b, input int busy_at, input int dsr_at);
        for (int c = 0; c < 40; c++) begin
            n_cmp++; if (tx !== frame_bit(b, c)) begin n_fail++; $display("FAIL frame_tx c=%0d got %b want %b", c, tx, frame_bit(b, c)); end
            if (c == 1 && dsr_at != 0) begin
                n_cmp++; if (WR !== 1'b0) begin n_fail++; $display("FAIL wr_pulse got %b want 0", WR); end
            end
            if (c == 20) begin
                n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL busy_int got %b want 0", INT); end
            end
            if (c == busy_at) begin MDR = 16'h0055; LD_DDR = 1'b1; end
            if (c == dsr_at) begin MDR = 16'h4123; LD_DSR = 1'b1; end
            tick();
            if (c == busy_at) begin
                LD_DDR = 1'b0;
                n_cmp++; if (WR !== 1'b0) begin n_fail++; $display("FAIL busy_wr got %b want 0", WR); end
                n_cmp++; if (DDR !== exp_ddr) begin n_fail++; $display("FAIL busy_ddr got %h want %h", DDR, exp_ddr); end
            end
            if (c == dsr_at) begin
                LD_DSR = 1'b0;
                exp_low = 15'h4123;
                n_cmp++; if (DSR !== 16'h4123) begin n_fail++; $display("FAIL mid_dsr got %h want 4123", DSR); end
                n_cmp++; if (WR !== 1'b1) begin n_fail++; $display("FAIL mid_wr got %b want 1", WR); end
            end
        end
        n_cmp++; if (DSR !== {1'b1, exp_low}) begin n_fail++; $display("FAIL end_dsr got %h want %h", DSR, {1'b1, exp_low}); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL end_tx got %b want 1", tx); end
        n_cmp++; if (INT !== exp_low[14]) begin n_fail++; $display("FAIL end_int got %b want %b", INT, exp_low[14]); end
    endtask

    task automatic test_frame();
        accept(16'h0041);
        check_frame(8'h41, -1, -1);
    endtask

    task automatic test_busy();
        accept(16'h0041);
        check_frame(8'h41, 10, -1);
    endtask

    task automatic test_back_to_back();
        accept(16'h00FF);
        n_cmp++; if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start got %b want 0", tx); end
        check_frame(8'hFF, -1, 25);
    endtask

    task automatic test_simultaneous();
        MDR = 16'h4000;
        LD_DSR = 1'b1;
        LD_DDR = 1'b1;
        tick();
        LD_DSR = 1'b0;
        LD_DDR = 1'b0;
        exp_low = 15'h4000;
        n_cmp++; if (DSR !== 16'hC000) begin n_fail++; $display("FAIL simul_dsr got %h want c000", DSR); end
        n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL simul_int got %b want 1", INT); end
        n_cmp++; if (WR !== 1'b1) begin n_fail++; $display("FAIL simul_wr got %b want 1", WR); end
        n_cmp++; if (DDR !== exp_ddr) begin n_fail++; $display("FAIL simul_ddr got %h want %h", DDR, exp_ddr); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL simul_tx i=%0d got %b want 1", i, tx); end
            tick();
        end
    endtask

    task automatic test_int();
        MDR = 16'h0000;
        LD_DSR = 1'b1;
        tick();
        LD_DSR = 1'b0;
        exp_low = '0;
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL int_clear got %b want 0", INT); end
        MDR = 16'h4000;
        LD_DSR = 1'b1;
        tick();
        LD_DSR = 1'b0;
        exp_low = 15'h4000;
        n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL int_set got %b want 1", INT); end
        accept(16'h0012);
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL int_busy got %b want 0", INT); end
        check_frame(8'h12, -1, -1);
    endtask

    task automatic test_reset_mid();
        accept(16'h0041);
        for (int c = 0; c < 17; c++) tick();
        n_cmp++; if (tx !== 1'b0) begin n_fail++; $display("FAIL pre_rst_tx got %b want 0", tx); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx got %b want 1", tx); end
        n_cmp++; if (DSR !== 16'h8000) begin n_fail++; $display("FAIL rstmid_dsr got %h want 8000", DSR); end
        n_cmp++; if (DDR !== 16'h0000) begin n_fail++; $display("FAIL rstmid_ddr got %h want 0000", DDR); end
        #10;
        rst_n = 1'b1;
        exp_low = '0;
        exp_ddr = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL post_rst_tx i=%0d got %b want 1", i, tx); end
        end
        accept(16'h013C);
        check_frame(8'h3C, -1, -1);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_busy();
        test_back_to_back();
        test_simultaneous();
        test_int();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
